ip_codma_read_machine: RTL

Bus read engine of the CODMA. Accepts read requests (address + size code) from the main machine and issues one burst on the memory bus. Collects 64-bit beats into an 8×32-bit data register and reports progress through `rd_state_r`/`rd_state_next_s`, which the main machine consumes directly. Flags bus errors, illegal requests and timeouts.

---
 rtl/ip_codma_pkg.sv | 30 +++
 rtl/ip_codma_read_machine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ip_codma_pkg.sv
// ip_codma_pkg
//   Shared types and constants for the CODMA blocks.
//   read_state_t  : read engine state, consumed directly by the main machine.
//   RD_SZ_*       : bus size codes accepted by the read engine.
//   size_to_beats : size code -> number of 64-bit beats (0 marks an illegal code).
package ip_codma_pkg;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_ASK     = 2'd1,
    RD_GRANTED = 2'd2,
    RD_ERROR   = 2'd3
  } read_state_t;

  localparam logic [7:0] RD_SZ_8B  = 8'd3;
  localparam logic [7:0] RD_SZ_16B = 8'd8;
  localparam logic [7:0] RD_SZ_32B = 8'd9;

  function automatic logic [2:0] size_to_beats(input logic [7:0] size);
    logic [2:0] beats;
    case (size)
      RD_SZ_8B:  beats = 3'd1;
      RD_SZ_16B: beats = 3'd2;
      RD_SZ_32B: beats = 3'd4;
      default:   beats = 3'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ip_codma_read_machine.sv
// ip_codma_read_machine
//   Bus read engine of the CODMA. Takes one read request (address + size code)
//   from the main machine, issues a single burst on the memory bus and gathers
//   the 64-bit beats into an 8x32-bit data register.
//
// Ports
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   reg_addr, reg_size : request byte address (8-byte aligned) and size code
//   need_read_i        : request level from the main machine
//   need_read_o        : request-still-pending echo back to the main machine
//   data_reg           : collected read data, word 2k/2k+1 from beat k
//   rd_state_r         : registered state
//   rd_state_next_s    : combinational next state
//   rd_state_error     : one-cycle error pulse (high while in RD_ERROR)
//   bus_read_o         : read request to the bus (RD_ASK only)
//   bus_addr_o         : latched burst start address
//   bus_size_o         : latched size code
//   bus_gnt_i          : bus grant, meaningful while bus_read_o = 1
//   bus_rvalid_i       : read beat valid
//   bus_rdata_i        : read beat data
//   bus_error_i        : bus error, honoured in RD_ASK / RD_GRANTED
module ip_codma_read_machine
  import ip_codma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [31:0]      reg_addr,
  input  logic [7:0]       reg_size,
  input  logic             need_read_i,
  output logic             need_read_o,
  output logic [7:0][31:0] data_reg,
  output read_state_t      rd_state_r,
  output read_state_t      rd_state_next_s,
  output logic             rd_state_error,
  output logic             bus_read_o,
  output logic [31:0]      bus_addr_o,
  output logic [7:0]       bus_size_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [63:0]      bus_rdata_i,
  input  logic             bus_error_i
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    beats;
  logic [1:0]    last_idx;
  logic          req_legal;
  logic          tmo_hit;
  logic          beat_accept;
  logic          last_beat;

  // Burst length always comes from the latched size, never the live input.
  assign beats     = size_to_beats(bus_size_o);
  assign last_idx  = 2'(beats - 3'd1);
  assign req_legal = (size_to_beats(reg_size) != 3'd0) && (reg_addr[2:0] == 3'd0);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  // Next state. Within RD_ASK/RD_GRANTED the priority is:
  // abort (request dropped) > error (bus error / timeout) > grant or beat.
  always_comb begin
    rd_state_next_s = rd_state_r;
    beat_accept     = 1'b0;
    last_beat       = 1'b0;
    case (rd_state_r)
      RD_IDLE: begin
        if (need_read_i) begin
          rd_state_next_s = req_legal ? RD_ASK : RD_ERROR;
        end
      end
      RD_ASK: begin
        if (!need_read_i) begin
          rd_state_next_s = RD_IDLE;
        end else if (bus_error_i || tmo_hit) begin
          rd_state_next_s = RD_ERROR;
        end else if (bus_gnt_i) begin
          rd_state_next_s = RD_GRANTED;
        end
      end
      RD_GRANTED: begin
        if (!need_read_i) begin
          rd_state_next_s = RD_IDLE;
        end else if (bus_error_i || tmo_hit) begin
          rd_state_next_s = RD_ERROR;
        end else if (bus_rvalid_i) begin
          beat_accept = 1'b1;
          if (beat_cnt == last_idx) begin
            last_beat       = 1'b1;
            rd_state_next_s = RD_IDLE;
          end
        end
      end
      RD_ERROR: begin
        rd_state_next_s = RD_IDLE;
      end
      default: begin
        rd_state_next_s = RD_IDLE;
      end
    endcase
  end

  assign need_read_o = need_read_i && !last_beat && (rd_state_next_s != RD_ERROR);
  // Combinational so an abort in RD_ASK withdraws the request in the same cycle.
  assign bus_read_o  = (rd_state_r == RD_ASK) && need_read_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_state_r     <= RD_IDLE;
      rd_state_error <= 1'b0;
      beat_cnt       <= '0;
      tmo_cnt        <= '0;
      bus_addr_o     <= '0;
      bus_size_o     <= '0;
      data_reg       <= '0;
    end else begin
      rd_state_r     <= rd_state_next_s;
      // Registered from the next state, so it is high exactly while in RD_ERROR.
      rd_state_error <= (rd_state_next_s == RD_ERROR);
      case (rd_state_r)
        RD_IDLE: begin
          if (rd_state_next_s == RD_ASK) begin
            bus_addr_o <= reg_addr;
            bus_size_o <= reg_size;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
          end
        end
        RD_ASK: begin
          if (rd_state_next_s == RD_GRANTED) begin
            tmo_cnt <= '0;
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RD_GRANTED: begin
          if (beat_accept) begin
            data_reg[{beat_cnt, 1'b0}] <= bus_rdata_i[31:0];
            data_reg[{beat_cnt, 1'b1}] <= bus_rdata_i[63:32];
            if (beat_cnt != 2'b11) begin
              beat_cnt <= beat_cnt + 2'd1;
            end
            tmo_cnt <= '0;
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
